// File: rtl/cic_filter_gen_pkg.sv
// Shared constants, width helpers and the accumulator type for cic_filter_gen.
// Width helpers are also used when the filter is built with non-default R/N/DW.
package cic_filter_gen_pkg;

  localparam int R_DEF  = 4;
  localparam int N_DEF  = 3;
  localparam int DW_DEF = 16;

  // Bit growth of an N-stage CIC decimating by R, which is also the output shift.
  function automatic int cic_shift(input int r, input int n);
    return n * $clog2(r);
  endfunction

  function automatic int cic_acc_w(input int dw, input int r, input int n);
    return dw + cic_shift(r, n);
  endfunction

  localparam int AW_DEF = cic_acc_w(DW_DEF, R_DEF, N_DEF);

  typedef logic signed [AW_DEF-1:0] acc_t;

endpackage

// File: rtl/cic_filter_gen_integrator.sv
// One enabled AW-bit integrator stage; two's-complement wrap-around is intended.
module cic_integrator #(
  parameter int AW = cic_filter_gen_pkg::AW_DEF
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 en,
  input  logic signed [AW-1:0] din,
  output logic signed [AW-1:0] acc
);

  logic signed [AW-1:0] acc_q;
  logic signed [AW-1:0] acc_d;

  always_comb begin
    acc_d = acc_q;
    if (en) acc_d = acc_q + din;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/cic_filter_gen.sv
// N-stage CIC decimator by R with unity DC gain (M = 1, always ready, no tready).
// Optional macro CIC_FILTER_GEN_ROUND_EN selects round-half-up instead of floor at the output shift.
module cic_filter_gen
  import cic_filter_gen_pkg::*;
#(
  parameter int R  = R_DEF,
  parameter int N  = N_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          aclk,
  input  logic          areset,
  input  logic [DW-1:0] s_axis_data_tdata,
  input  logic          s_axis_data_tvalid,
  output logic [DW-1:0] m_axis_data_tdata,
  output logic          m_axis_data_tvalid
);

  localparam int S  = cic_shift(R, N);
  localparam int AW = cic_acc_w(DW, R, N);
  localparam int CW = $clog2(R);

`ifdef CIC_FILTER_GEN_ROUND_EN
  localparam logic signed [AW-1:0] RND = AW'(1) << (S - 1);
`else
  localparam logic signed [AW-1:0] RND = '0;
`endif

  logic                 accept;
  logic signed [AW-1:0] in_ext;
  logic signed [AW-1:0] integ [N];

  assign accept = s_axis_data_tvalid;
  assign in_ext = {{(AW-DW){s_axis_data_tdata[DW-1]}}, s_axis_data_tdata};

  for (genvar k = 0; k < N; k++) begin : g_int
    logic signed [AW-1:0] din;
    if (k == 0) begin : g_first
      assign din = in_ext;
    end else begin : g_rest
      assign din = integ[k-1];
    end
    cic_integrator #(.AW(AW)) u_int (
      .aclk   (aclk),
      .areset (areset),
      .en     (accept),
      .din    (din),
      .acc    (integ[k])
    );
  end

  logic [CW-1:0]        phase_q, phase_d;
  logic [N-1:0]         sr_q, sr_d;
  logic signed [AW-1:0] dly_q [N];
  logic signed [AW-1:0] dly_d [N];
  logic signed [AW-1:0] c [N+1];
  logic signed [AW-1:0] comb_q, comb_d;
  logic signed [AW-1:0] rounded;
  logic                 fire_q, fire_d;
  logic [DW-1:0]        tdata_q, tdata_d;
  logic                 tvalid_q, tvalid_d;
  logic                 wrap;
  logic                 fire;

  // The wrap strobe rides a shift register clocked by accepted samples, so the
  // combs fire once the integrator pipeline has absorbed the phase's last sample.
  always_comb begin
    wrap    = accept && (phase_q == CW'(R - 1));
    phase_d = phase_q;
    sr_d    = sr_q;
    if (accept) begin
      phase_d = wrap ? '0 : phase_q + CW'(1);
      sr_d[0] = wrap;
      for (int k = 1; k < N; k++) sr_d[k] = sr_q[k-1];
    end
    fire = accept && sr_q[N-1];

    c[0] = integ[N-1];
    for (int k = 0; k < N; k++) begin
      c[k+1]   = c[k] - dly_q[k];
      dly_d[k] = fire ? c[k] : dly_q[k];
    end
    comb_d = fire ? c[N] : comb_q;
    fire_d = fire;

    rounded  = comb_q + RND;
    tvalid_d = fire_q;
    tdata_d  = fire_q ? DW'(rounded >>> S) : tdata_q;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      phase_q  <= '0;
      sr_q     <= '0;
      comb_q   <= '0;
      fire_q   <= 1'b0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      for (int k = 0; k < N; k++) dly_q[k] <= '0;
    end else begin
      phase_q  <= phase_d;
      sr_q     <= sr_d;
      comb_q   <= comb_d;
      fire_q   <= fire_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      for (int k = 0; k < N; k++) dly_q[k] <= dly_d[k];
    end
  end

  assign m_axis_data_tdata  = tdata_q;
  assign m_axis_data_tvalid = tvalid_q;

endmodule

// File: tb/tb_cic_filter_gen.sv
// Self-checking bench for cic_filter_gen: a convolution model of the CIC
// impulse response predicts every output; directed tests pin the model.
module tb_cic_filter_gen;

  localparam int R   = 4;
  localparam int N   = 3;
  localparam int DW  = 16;
  localparam int S   = 6;
  localparam int LEN = N * (R - 1) + 1;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;

  always #5 aclk = ~aclk;

  cic_filter_gen #(.R(R), .N(N), .DW(DW)) dut (
    .aclk               (aclk),
    .areset             (areset),
    .s_axis_data_tdata  (s_tdata),
    .s_axis_data_tvalid (s_tvalid),
    .m_axis_data_tdata  (m_tdata),
    .m_axis_data_tvalid (m_tvalid)
  );

  int          compared = 0;
  int          mismatched = 0;
  int          h [LEN];
  int          xs [$];
  logic [DW-1:0] exp_q [$];
  int          got_q [$];
  int          pulse_cyc [$];
  logic [1:0]  exp_pipe = '0;
  int          cyc = 0;
  int          acc4_cyc = -1;
  int          last_out = 0;

  task automatic chk(input string name, input int act, input int expv);
    compared++;
    if (act != expv) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Impulse response of N cascaded length-R boxcars.
  function automatic void build_h();
    int tmp [LEN];
    for (int i = 0; i < LEN; i++) h[i] = (i == 0) ? 1 : 0;
    repeat (N) begin
      for (int i = 0; i < LEN; i++) begin
        tmp[i] = 0;
        for (int j = 0; j < R; j++) if (i - j >= 0) tmp[i] += h[i-j];
      end
      for (int i = 0; i < LEN; i++) h[i] = tmp[i];
    end
  endfunction

  function automatic int model_out(input int idx);
    longint acc = 0;
    for (int j = 0; j < LEN; j++) if (idx - j >= 0) acc += longint'(h[j]) * longint'(xs[idx-j]);
`ifdef CIC_FILTER_GEN_ROUND_EN
    acc += longint'(1) << (S - 1);
`endif
    return int'(acc >>> S);
  endfunction

  function automatic int sine_at(input int i);
    return $rtoi(32767.0 * $sin(6.283185307179586 * i / 100.0));
  endfunction

  // Model: output m is y[R*m+R-1] of the full-rate filtered stream; it leaves the
  // DUT one cycle after the N-th accepted sample following the end of its phase.
  always @(posedge aclk or posedge areset) begin
    int n;
    if (areset) begin
      xs.delete();
      exp_q.delete();
      got_q.delete();
      pulse_cyc.delete();
      exp_pipe = '0;
      last_out = 0;
      acc4_cyc = -1;
    end else begin
      cyc++;
      exp_pipe[1] = exp_pipe[0];
      exp_pipe[0] = 1'b0;
      if (s_tvalid) begin
        xs.push_back(int'($signed(s_tdata)));
        n = xs.size() - 1;
        if (n == R - 1) acc4_cyc = cyc;
        if (n >= R - 1 + N && ((n - (R - 1 + N)) % R) == 0) begin
          exp_q.push_back(DW'(model_out(n - N)));
          exp_pipe[0] = 1'b1;
        end
      end
    end
  end

  // Compare every cycle: pulse timing, new values, and hold between pulses.
  always @(negedge aclk) begin
    logic [DW-1:0] e;
    if (!areset) begin
      chk("tvalid", int'(m_tvalid), int'(exp_pipe[1]));
      if (exp_pipe[1]) begin
        if (exp_q.size() == 0) begin
          chk("exp_queue_nonempty", 0, 1);
        end else begin
          e = exp_q.pop_front();
          chk("tdata_new", int'($signed(m_tdata)), int'($signed(e)));
          last_out = int'($signed(e));
          got_q.push_back(int'($signed(m_tdata)));
          pulse_cyc.push_back(cyc);
        end
      end else begin
        chk("tdata_hold", int'($signed(m_tdata)), last_out);
      end
    end
  end

  task automatic drive(input int val, input bit v);
    s_tdata  = DW'(val);
    s_tvalid = v;
    @(negedge aclk);
  endtask

  task automatic do_reset();
    areset   = 1'b1;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    @(negedge aclk);
    #1;
    chk("reset_tdata", int'(m_tdata), 0);
    chk("reset_tvalid", int'(m_tvalid), 0);
    @(negedge aclk);
    areset = 1'b0;
  endtask

  task automatic end_test(input string name);
    repeat (4) drive(0, 1'b0);
    chk({name, "_drain"}, exp_q.size(), 0);
  endtask

  initial begin
    int pk;
    build_h();
    chk("h_tap3", h[3], 10);
    chk("h_tap7", h[7], 6);

    // DC 1000: two transients, then 1000 every 4 cycles.
    do_reset();
    repeat (40) drive(1000, 1'b1);
    end_test("dc");
    chk("dc_count", got_q.size(), 9);
    if (got_q.size() >= 9) begin
`ifdef CIC_FILTER_GEN_ROUND_EN
      chk("dc_first", got_q[0], 313);
      chk("dc_second", got_q[1], 938);
`else
      chk("dc_first", got_q[0], 312);
      chk("dc_second", got_q[1], 937);
`endif
      for (int i = 2; i < got_q.size(); i++) chk("dc_settled", got_q[i], 1000);
      chk("dc_latency", pulse_cyc[0] - acc4_cyc, N + 1);
      for (int i = 1; i < pulse_cyc.size(); i++) chk("dc_spacing", pulse_cyc[i] - pulse_cyc[i-1], 4);
    end

    // Impulse 64: taps h[3], h[7], then zero.
    do_reset();
    drive(64, 1'b1);
    repeat (30) drive(0, 1'b1);
    end_test("imp");
    chk("imp_count", got_q.size(), 7);
    if (got_q.size() >= 3) begin
      chk("imp_out0", got_q[0], 10);
      chk("imp_out1", got_q[1], 6);
      chk("imp_out2", got_q[2], 0);
    end

    // Full scale negative and positive, across many integrator wraps.
    do_reset();
    repeat (60) drive(-32768, 1'b1);
    end_test("fs_neg");
    chk("fs_neg_count", got_q.size(), 14);
    if (got_q.size() > 0) chk("fs_neg_settled", got_q[got_q.size()-1], -32768);
    do_reset();
    repeat (60) drive(32767, 1'b1);
    end_test("fs_pos");
    chk("fs_pos_count", got_q.size(), 14);
    if (got_q.size() > 0) chk("fs_pos_settled", got_q[got_q.size()-1], 32767);

    // Valid gating: half-rate input, pulses every 8 cycles.
    do_reset();
    for (int i = 0; i < 80; i++) drive(500, (i % 2) == 0);
    end_test("gate");
    chk("gate_count", got_q.size(), 9);
    if (got_q.size() >= 2) begin
      chk("gate_settled", got_q[got_q.size()-1], 500);
      for (int i = 1; i < pulse_cyc.size(); i++) chk("gate_spacing", pulse_cyc[i] - pulse_cyc[i-1], 8);
    end

    // Reset for 1 ns mid-phase during a sine.
    do_reset();
    for (int i = 0; i < 30; i++) drive(sine_at(i), 1'b1);
    s_tdata  = DW'(sine_at(30));
    s_tvalid = 1'b1;
    #2 areset = 1'b1;
    #1;
    chk("midrst_tdata", int'(m_tdata), 0);
    chk("midrst_tvalid", int'(m_tvalid), 0);
    areset = 1'b0;
    @(negedge aclk);
    for (int i = 31; i < 90; i++) drive(sine_at(i), 1'b1);
    end_test("midrst");
    chk("midrst_has_pulse", int'(pulse_cyc.size() > 0), 1);
    if (pulse_cyc.size() > 0) chk("midrst_latency", pulse_cyc[0] - acc4_cyc, N + 1);

    // 10 kHz full-scale sine at 1 MSps.
    do_reset();
    for (int i = 0; i < 400; i++) drive(sine_at(i), 1'b1);
    end_test("sine");
    chk("sine_count", got_q.size(), 99);
    pk = 0;
    foreach (got_q[i]) if ((got_q[i] < 0 ? -got_q[i] : got_q[i]) > pk) pk = (got_q[i] < 0 ? -got_q[i] : got_q[i]);
    chk("sine_peak_in_band", int'(pk >= 32373 && pk <= 32768), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
